// File: rtl/sm83_pkg.sv
// Shared SM83 front-end types: fetch FSM states, CB prefix and opcode length/legality tables.
package sm83_pkg;

  typedef logic [7:0] instr_t;

  typedef enum logic [2:0] {S_OP, S_CB, S_LO, S_HI, S_HOLD} fetch_state_t;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  // Number of immediate bytes following an unprefixed opcode.
  function automatic logic [1:0] imm_len(input logic [7:0] op);
    logic [1:0] len;
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:                               len = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:                 len = 2'd2;
      default:                                                  len = 2'd0;
    endcase
    return len;
  endfunction

  function automatic logic is_illegal(input logic [7:0] op);
    logic ill;
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: ill = 1'b1;
      default:                           ill = 1'b0;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/sm83_fetch_unit.sv
// SM83 fetch front end: reads opcode, optional CB byte and immediates, then holds
// one complete instruction bundle for the decoder.
module sm83_fetch_unit
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_op,
  output logic        instr_cb,
  output logic [15:0] instr_imm,
  output logic [1:0]  instr_len,
  output logic        instr_illegal,
  output logic [15:0] instr_pc,
  output logic [15:0] next_pc
);

  fetch_state_t state_reg;
  logic [15:0]  pc_reg;
  logic [15:0]  mem_addr_reg;
  logic         mem_req_reg;
  logic         drop_reg;
  logic         valid_reg;
  instr_t       op_reg;
  logic         cb_reg;
  logic [15:0]  imm_reg;
  logic [1:0]   len_reg;
  logic         illegal_reg;
  logic [15:0]  instr_pc_reg;
  logic [15:0]  next_pc_reg;

  logic [15:0]  pc_inc;
  logic [1:0]   op_imm_len;
  logic         byte_taken;
  logic         bundle_done;

  always_comb begin
    pc_inc      = pc_reg + 16'd1;
    op_imm_len  = imm_len(mem_rdata);
    // A byte belongs to the current bundle only if it was not requested before a redirect.
    byte_taken  = mem_req_reg && mem_ack && !drop_reg && !redirect && (state_reg != S_HOLD);
    bundle_done = 1'b0;
    if (byte_taken) begin
      case (state_reg)
        S_OP:    bundle_done = (mem_rdata != CB_PREFIX) && (op_imm_len == 2'd0);
        S_CB:    bundle_done = 1'b1;
        S_LO:    bundle_done = (len_reg != 2'd3);
        S_HI:    bundle_done = 1'b1;
        default: bundle_done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_OP;
      pc_reg       <= RESET_PC;
      mem_addr_reg <= RESET_PC;
      mem_req_reg  <= 1'b0;
      drop_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      op_reg       <= '0;
      cb_reg       <= 1'b0;
      imm_reg      <= '0;
      len_reg      <= '0;
      illegal_reg  <= 1'b0;
      instr_pc_reg <= '0;
      next_pc_reg  <= '0;
    end else if (redirect) begin
      state_reg <= S_OP;
      pc_reg    <= redirect_pc;
      valid_reg <= 1'b0;
      // An unacknowledged read must finish at its old address; its data is thrown away.
      if (mem_req_reg && !mem_ack) begin
        drop_reg <= 1'b1;
      end else begin
        drop_reg     <= 1'b0;
        mem_req_reg  <= fetch_en;
        mem_addr_reg <= redirect_pc;
      end
    end else if (drop_reg) begin
      if (mem_ack) begin
        drop_reg     <= 1'b0;
        mem_req_reg  <= fetch_en;
        mem_addr_reg <= pc_reg;
      end
    end else begin
      if (byte_taken) begin
        pc_reg       <= pc_inc;
        mem_addr_reg <= pc_inc;
      end
      case (state_reg)
        S_OP: begin
          if (!mem_req_reg) begin
            mem_req_reg  <= fetch_en;
            mem_addr_reg <= pc_reg;
          end else if (mem_ack) begin
            op_reg       <= mem_rdata;
            instr_pc_reg <= pc_reg;
            cb_reg       <= 1'b0;
            imm_reg      <= '0;
            if (mem_rdata == CB_PREFIX) begin
              len_reg     <= 2'd2;
              illegal_reg <= 1'b0;
              state_reg   <= S_CB;
            end else begin
              len_reg     <= op_imm_len + 2'd1;
              illegal_reg <= is_illegal(mem_rdata);
              state_reg   <= S_LO;
            end
          end
        end
        S_CB: if (mem_ack) begin
          op_reg <= mem_rdata;
          cb_reg <= 1'b1;
        end
        S_LO: if (mem_ack) begin
          imm_reg[7:0] <= mem_rdata;
          state_reg    <= S_HI;
        end
        S_HI: if (mem_ack) imm_reg[15:8] <= mem_rdata;
        S_HOLD: if (instr_ready) begin
          valid_reg   <= 1'b0;
          state_reg   <= S_OP;
          mem_req_reg <= fetch_en;
        end
        default: state_reg <= S_OP;
      endcase
      // Completion overrides the per-state next-state chosen above.
      if (bundle_done) begin
        state_reg   <= S_HOLD;
        valid_reg   <= 1'b1;
        mem_req_reg <= 1'b0;
        next_pc_reg <= pc_inc;
      end
    end
  end

  assign mem_req       = mem_req_reg;
  assign mem_addr      = mem_addr_reg;
  assign instr_valid   = valid_reg;
  assign instr_op      = op_reg;
  assign instr_cb      = cb_reg;
  assign instr_imm     = imm_reg;
  assign instr_len     = len_reg;
  assign instr_illegal = illegal_reg;
  assign instr_pc      = instr_pc_reg;
  assign next_pc       = next_pc_reg;

endmodule

// File: tb/tb_sm83_fetch_unit.sv
// Directed bench for sm83_fetch_unit: byte-addressed memory with programmable ack latency
// and a queue of expected bundles checked at each accept.
module tb_sm83_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_op;
  logic        instr_cb;
  logic [15:0] instr_imm;
  logic [1:0]  instr_len;
  logic        instr_illegal;
  logic [15:0] instr_pc;
  logic [15:0] next_pc;

  sm83_fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_cb(instr_cb), .instr_imm(instr_imm), .instr_len(instr_len),
    .instr_illegal(instr_illegal), .instr_pc(instr_pc), .next_pc(next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  int ack_delay;
  int wait_cnt;
  int checks;
  int errors;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  typedef struct {
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic        ill;
    logic [15:0] pc;
    logic [15:0] npc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] op, input logic cb, input logic [15:0] imm,
                      input logic [1:0] len, input logic ill, input logic [15:0] pc,
                      input logic [15:0] npc);
    exp_t e;
    e.op = op; e.cb = cb; e.imm = imm; e.len = len; e.ill = ill; e.pc = pc; e.npc = npc;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every accepted bundle is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_valid: observed bundle pc=%h op=%h expected none", instr_pc, instr_op);
      end else begin
        mon_e = exp_q.pop_front();
        $display("bundle pc=%h op=%h cb=%0d imm=%h len=%0d ill=%0d next_pc=%h",
                 instr_pc, instr_op, instr_cb, instr_imm, instr_len, instr_illegal, next_pc);
        chk("op", instr_op, mon_e.op);
        chk("cb", instr_cb, mon_e.cb);
        chk("imm", instr_imm, mon_e.imm);
        chk("len", instr_len, mon_e.len);
        chk("illegal", instr_illegal, mon_e.ill);
        chk("instr_pc", instr_pc, mon_e.pc);
        chk("next_pc", next_pc, mon_e.npc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, instr_valid, 1'b1);
  endtask

  task automatic fetch_at(input logic [15:0] addr, input string tag);
    fetch_en    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = addr;
    tick();
    redirect = 1'b0;
    wait_valid(tag);
    fetch_en = 1'b0;
    tick();
  endtask

  logic [7:0]  s_op;
  logic [15:0] s_imm, s_pc, s_npc;
  logic [1:0]  s_len;

  initial begin
    checks = 0; errors = 0; ack_delay = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'h50; mem[16'h0002] = 8'h01;
    mem[16'h0010] = 8'hCB; mem[16'h0011] = 8'h37;
    mem[16'h0020] = 8'hE0; mem[16'h0021] = 8'h44;
    mem[16'h0030] = 8'h3E; mem[16'h0031] = 8'h5A;
    mem[16'h0040] = 8'h3E; mem[16'h0041] = 8'h77;
    mem[16'h0050] = 8'hD3;
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (3) tick();

    chk("rst_mem_addr", mem_addr, 16'h0100);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_op", instr_op, 8'h00);
    chk("rst_imm", instr_imm, 16'h0000);
    chk("rst_len", instr_len, 2'd0);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    chk("rst_next_pc", next_pc, 16'h0000);

    // NOP at boot entry: request one cycle after reset release, bundle one cycle later.
    push(8'h00, 1'b0, 16'h0000, 2'd1, 1'b0, 16'h0100, 16'h0101);
    rst = 1'b0; fetch_en = 1'b1;
    tick();
    chk("boot_req", mem_req, 1'b1);
    chk("boot_addr", mem_addr, 16'h0100);
    chk("boot_not_yet_valid", instr_valid, 1'b0);
    tick();
    chk("boot_latency_valid", instr_valid, 1'b1);
    fetch_en = 1'b0;
    tick();

    push(8'hC3, 1'b0, 16'h0150, 2'd3, 1'b0, 16'h0000, 16'h0003);
    fetch_at(16'h0000, "jp");
    push(8'h37, 1'b1, 16'h0000, 2'd2, 1'b0, 16'h0010, 16'h0012);
    fetch_at(16'h0010, "cb");
    push(8'hE0, 1'b0, 16'h0044, 2'd2, 1'b0, 16'h0020, 16'h0022);
    fetch_at(16'h0020, "ldh");

    // Decoder stall: bundle frozen, bus idle; on accept the next fetch starts at once.
    push(8'h3E, 1'b0, 16'h005A, 2'd2, 1'b0, 16'h0030, 16'h0032);
    push(8'h00, 1'b0, 16'h0000, 2'd1, 1'b0, 16'h0032, 16'h0033);
    instr_ready = 1'b0;
    fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 16'h0030;
    tick();
    redirect = 1'b0;
    wait_valid("stall");
    s_op = instr_op; s_imm = instr_imm; s_pc = instr_pc; s_npc = next_pc; s_len = instr_len;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_mem_req", mem_req, 1'b0);
      chk("stall_op", instr_op, s_op);
      chk("stall_imm", instr_imm, s_imm);
      chk("stall_len", instr_len, s_len);
      chk("stall_pc", instr_pc, s_pc);
      chk("stall_next_pc", next_pc, s_npc);
    end
    instr_ready = 1'b1;
    tick();
    chk("accept_valid_drop", instr_valid, 1'b0);
    chk("accept_mem_req", mem_req, 1'b1);
    chk("accept_mem_addr", mem_addr, 16'h0032);
    fetch_en = 1'b0;
    wait_valid("after_stall");
    tick();

    // Redirect while the low immediate byte is still pending on a slow bus.
    push(8'h00, 1'b0, 16'h0000, 2'd1, 1'b0, 16'h0038, 16'h0039);
    ack_delay = 3;
    fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    for (int n = 0; n < 20 && !(mem_req && mem_addr == 16'h0041); n++) tick();
    chk("lo_reached", mem_addr, 16'h0041);
    redirect = 1'b1; redirect_pc = 16'h0038;
    tick();
    redirect = 1'b0;
    for (int n = 0; n < 10 && mem_addr == 16'h0041; n++) begin
      chk("redir_req_held", mem_req, 1'b1);
      chk("redir_no_valid", instr_valid, 1'b0);
      tick();
    end
    chk("redir_new_addr", mem_addr, 16'h0038);
    wait_valid("redir");
    fetch_en = 1'b0;
    tick();
    ack_delay = 0;

    // Instruction bytes straddling the top of the address space.
    mem[16'hFFFF] = 8'h01; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    push(8'h01, 1'b0, 16'h1234, 2'd3, 1'b0, 16'hFFFF, 16'h0002);
    fetch_at(16'hFFFF, "wrap");
    push(8'hD3, 1'b0, 16'h0000, 2'd1, 1'b1, 16'h0050, 16'h0051);
    fetch_at(16'h0050, "illegal");

    // Reset while a bundle is held unaccepted.
    instr_ready = 1'b0;
    fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 16'h0060;
    tick();
    redirect = 1'b0;
    wait_valid("midrst");
    fetch_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_valid", instr_valid, 1'b0);
    chk("midrst_mem_addr", mem_addr, 16'h0100);
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_instr_pc", instr_pc, 16'h0000);
    rst = 1'b0; instr_ready = 1'b1;
    repeat (2) tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
